level_triggered_data_capture: RTL and testbench

- Receive-side stage that sits directly downstream of the serial shifter.
- Consumes the sclk/sda pair, where sda changes during sclk low and is valid while sclk is high.
- Oversamples both lines with the fast system clock, samples sda mid-way into each sclk high level, and assembles bytes MSB first.
- Delivers each byte on a valid/ready interface, with overrun and frame-timeout detection.

---
 rtl/level_triggered_data_capture.sv | 233 +++++++++++++++++++++++
 tb/tb_level_triggered_data_capture.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/level_triggered_data_capture.sv
// -----------------------------------------------------------------------------
// level_triggered_data_capture
//
// Receive-side stage fed by the serial shifter. sda changes while sclk is low
// and is valid while sclk is high. Both lines are oversampled with clk; sda is
// sampled once, SAMPLE_DLY cycles into each synchronised sclk high level, and
// the bits are assembled MSB first. Completed words go to a one-entry output
// holding register with a valid/ready handshake. If that register is still
// full when a new word completes, the new word is dropped and the sticky
// overrun flag is set. If no sclk edge arrives for TIMEOUT cycles, a partial
// word is discarded and frame_err pulses for one cycle.
//
// Ports:
//   clk         fast system clock
//   rst_n       asynchronous active-low reset
//   sclk        serial clock from the shifter (asynchronous to clk)
//   sda         serial data from the shifter
//   data_out    last completed word
//   data_valid  data_out holds an unconsumed word
//   data_ready  consumer accepts data_out when high together with data_valid
//   overrun     sticky: a completed word was dropped
//   frame_err   one-cycle pulse: partial word discarded on timeout
//   bit_cnt     bits collected in the current word
// -----------------------------------------------------------------------------
module level_triggered_data_capture #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int SAMPLE_DLY  = 25,
    parameter int TIMEOUT     = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sclk,
    input  logic                          sda,
    output logic [DATA_W-1:0]             data_out,
    output logic                          data_valid,
    input  logic                          data_ready,
    output logic                          overrun,
    output logic                          frame_err,
    output logic [$clog2(DATA_W+1)-1:0]   bit_cnt
);

    localparam int CNT_W  = $clog2(DATA_W + 1);
    localparam int DLY_W  = $clog2(SAMPLE_DLY + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    // Fewer than two synchroniser flops is never safe, so clamp it here.
    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH_WAIT,
        ST_SAMPLED
    } state_t;

    // ------------------------------------------------------------------
    // Synchronisers. Stage 0 captures the pin; the last stage is the
    // version used by the rest of the logic.
    // ------------------------------------------------------------------
    logic [SYNC_N-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_N-1:0] sda_sync_q,  sda_sync_d;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_N; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sclk_sync_d[gi] = sclk;
                assign sda_sync_d[gi]  = sda;
            end else begin : g_rest
                assign sclk_sync_d[gi] = sclk_sync_q[gi-1];
                assign sda_sync_d[gi]  = sda_sync_q[gi-1];
            end
        end
    endgenerate

    logic sclk_s, sda_s;
    assign sclk_s = sclk_sync_q[SYNC_N-1];
    assign sda_s  = sda_sync_q[SYNC_N-1];

    logic sclk_prev_q, sclk_prev_d;
    logic sclk_rise, sclk_edge;

    assign sclk_prev_d = sclk_s;
    assign sclk_rise   = sclk_s & ~sclk_prev_q;
    assign sclk_edge   = sclk_s ^ sclk_prev_q;

    // ------------------------------------------------------------------
    // Receive state
    // ------------------------------------------------------------------
    state_t              state_q,    state_d;
    logic [DLY_W-1:0]    dly_cnt_q,  dly_cnt_d;
    logic [DATA_W-1:0]   shreg_q,    shreg_d;
    logic [CNT_W-1:0]    bit_cnt_q,  bit_cnt_d;
    logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic                frame_err_q, frame_err_d;

    logic [DATA_W-1:0]   data_out_q,   data_out_d;
    logic                data_valid_q, data_valid_d;
    logic                overrun_q,    overrun_d;

    logic                word_done;
    logic                timeout_hit;

    // bit_cnt sits at DATA_W for exactly one cycle after the last sample;
    // that cycle is the word transfer.
    assign word_done = (bit_cnt_q == CNT_W'(DATA_W));

    // The cycle in which idle_cnt steps onto TIMEOUT. idle_cnt saturates
    // there, so this fires once per stall and re-arms only after an edge.
    assign timeout_hit = !sclk_edge && (idle_cnt_q == IDLE_W'(TIMEOUT - 1));

    // ------------------------------------------------------------------
    // Next-state logic: FSM, shift register, counters
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        dly_cnt_d   = dly_cnt_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        frame_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sclk_rise) begin
                    dly_cnt_d = '0;
                    state_d   = ST_HIGH_WAIT;
                end
            end
            ST_HIGH_WAIT: begin
                if (!sclk_s) begin
                    // High level ended before the sample point: a glitch.
                    // Nothing is shifted and bit_cnt is left alone.
                    state_d = ST_IDLE;
                end else if (dly_cnt_q == DLY_W'(SAMPLE_DLY - 1)) begin
                    shreg_d   = {shreg_q[DATA_W-2:0], sda_s};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    state_d   = ST_SAMPLED;
                end else begin
                    dly_cnt_d = dly_cnt_q + 1'b1;
                end
            end
            ST_SAMPLED: begin
                // One sample per high level; wait for sclk to drop.
                if (!sclk_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A sample cannot coincide with the transfer cycle because the FSM
        // is in SAMPLED until sclk falls, so this override loses nothing.
        if (word_done) begin
            bit_cnt_d = '0;
        end

        if (sclk_edge) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != IDLE_W'(TIMEOUT)) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end

        if (timeout_hit && (bit_cnt_q != '0) && !word_done) begin
            frame_err_d = 1'b1;
            bit_cnt_d   = '0;
            shreg_d     = '0;
            state_d     = ST_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Output holding register and handshake
    // ------------------------------------------------------------------
    always_comb begin
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        overrun_d    = overrun_q;

        if (word_done) begin
            // An accept in the same cycle frees the register for the new word.
            if (!data_valid_q || data_ready) begin
                data_out_d   = shreg_q;
                data_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (data_valid_q && data_ready) begin
            data_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q  <= '0;
            sda_sync_q   <= '0;
            sclk_prev_q  <= 1'b0;
            state_q      <= ST_IDLE;
            dly_cnt_q    <= '0;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            idle_cnt_q   <= '0;
            frame_err_q  <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            sda_sync_q   <= sda_sync_d;
            sclk_prev_q  <= sclk_prev_d;
            state_q      <= state_d;
            dly_cnt_q    <= dly_cnt_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            frame_err_q  <= frame_err_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign overrun    = overrun_q;
    assign frame_err  = frame_err_q;
    assign bit_cnt    = bit_cnt_q;

endmodule

// File: tb/tb_level_triggered_data_capture.sv
// -----------------------------------------------------------------------------
// Testbench for level_triggered_data_capture.
// Stimulus pushes every word it expects the consumer to accept into exp_q;
// the monitor pops and compares on each accepted handshake.
// -----------------------------------------------------------------------------
module tb_level_triggered_data_capture;

    localparam int DATA_W = 8;
    localparam int HALF   = 51;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclk;
    logic       sda;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       overrun;
    logic       frame_err;
    logic [3:0] bit_cnt;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int accepted = 0;
    int valid_hi = 0;
    int fe_cnt   = 0;
    int fe_cyc   = 0;
    logic [7:0] exp_q[$];

    level_triggered_data_capture #(
        .DATA_W(8), .SYNC_STAGES(2), .SAMPLE_DLY(25), .TIMEOUT(255)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .sda(sda),
        .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
        .overrun(overrun), .frame_err(frame_err), .bit_cnt(bit_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Monitor: one line per accepted word.
    always @(negedge clk) begin
        if (rst_n) begin
            if (data_valid && data_ready) begin
                accepted++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_unexpected: got 0x%0h expected no word", data_out);
                end else begin
                    check("accept_data", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
                end
            end
            if (data_valid) valid_hi++;
            if (frame_err) begin
                fe_cnt++;
                fe_cyc = cyc;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        sda = b;
        tick(HALF);
        sclk = 1'b1;
        tick(HALF);
        sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = DATA_W - 1; i >= 0; i--) send_bit(b[i]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vh0;
        int fe0;
        int fall_cyc;
        bit found;

        rst_n = 1'b0; sclk = 1'b0; sda = 1'b0; data_ready = 1'b1;
        tick(3);
        check("rst_data_out",   {24'd0, data_out}, 32'h0);
        check("rst_data_valid", {31'd0, data_valid}, 32'h0);
        check("rst_overrun",    {31'd0, overrun}, 32'h0);
        check("rst_frame_err",  {31'd0, frame_err}, 32'h0);
        check("rst_bit_cnt",    {28'd0, bit_cnt}, 32'h0);
        rst_n = 1'b1;
        tick(5);

        // Back-to-back bytes with the consumer always ready.
        vh0 = valid_hi;
        exp_q.push_back(8'hAD);
        exp_q.push_back(8'h3C);
        send_byte(8'hAD);
        send_byte(8'h3C);
        tick(5);
        check("b2b_valid_cycles", vh0 < valid_hi ? valid_hi - vh0 : 0, 32'd2);
        check("b2b_overrun", {31'd0, overrun}, 32'h0);
        check("b2b_bit_cnt", {28'd0, bit_cnt}, 32'h0);

        // Accept of 0xAD in the same cycle 0x3C completes.
        data_ready = 1'b0;
        exp_q.push_back(8'hAD);
        exp_q.push_back(8'h3C);
        send_byte(8'hAD);
        check("sc_first_held", {24'd0, data_out}, 32'hAD);
        found = 1'b0;
        fork
            send_byte(8'h3C);
            begin
                for (int k = 0; k < 2000 && !found; k++) begin
                    @(posedge clk);
                    #1;
                    if (bit_cnt == 4'd8) begin
                        found = 1'b1;
                        data_ready = 1'b1;
                        @(posedge clk);
                        #1;
                        data_ready = 1'b0;
                    end
                end
            end
        join
        check("sc_word_done_seen", {31'd0, found}, 32'h1);
        check("sc_valid",   {31'd0, data_valid}, 32'h1);
        check("sc_data",    {24'd0, data_out}, 32'h3C);
        check("sc_overrun", {31'd0, overrun}, 32'h0);
        data_ready = 1'b1;
        tick(3);

        // Glitch between bits 3 and 4 of 0xAD.
        exp_q.push_back(8'hAD);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        tick(30);
        check("glitch_bit_cnt_before", {28'd0, bit_cnt}, 32'd4);
        sclk = 1'b1;
        tick(10);
        sclk = 1'b0;
        tick(60);
        check("glitch_bit_cnt_after", {28'd0, bit_cnt}, 32'd4);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        tick(5);

        // Timeout on a partial word, then a clean 0x5A.
        fe0 = fe_cnt;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        fall_cyc = cyc;
        tick(10);
        check("to_bit_cnt_partial", {28'd0, bit_cnt}, 32'd5);
        tick(290);
        check("to_frame_err_count", fe_cnt - fe0, 32'd1);
        check("to_frame_err_timing",
              ((fe_cyc - fall_cyc) >= 256 && (fe_cyc - fall_cyc) <= 260) ? 32'd1 : 32'd0, 32'd1);
        check("to_bit_cnt_cleared", {28'd0, bit_cnt}, 32'd0);
        exp_q.push_back(8'h5A);
        send_byte(8'h5A);
        tick(5);

        // Backpressure: second word dropped, overrun set.
        data_ready = 1'b0;
        exp_q.push_back(8'hAD);
        send_byte(8'hAD);
        send_byte(8'h3C);
        tick(5);
        check("bp_data_held", {24'd0, data_out}, 32'hAD);
        check("bp_valid",     {31'd0, data_valid}, 32'h1);
        check("bp_overrun",   {31'd0, overrun}, 32'h1);
        data_ready = 1'b1;
        tick(1);
        check("bp_valid_drop", {31'd0, data_valid}, 32'h0);
        check("bp_overrun_sticky", {31'd0, overrun}, 32'h1);

        // Asynchronous reset mid-word with a word pending.
        data_ready = 1'b0;
        send_byte(8'h11);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        tick(5);
        check("ar_pre_valid", {31'd0, data_valid}, 32'h1);
        check("ar_pre_bit_cnt", {28'd0, bit_cnt}, 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_data_out",   {24'd0, data_out}, 32'h0);
        check("ar_data_valid", {31'd0, data_valid}, 32'h0);
        check("ar_overrun",    {31'd0, overrun}, 32'h0);
        check("ar_frame_err",  {31'd0, frame_err}, 32'h0);
        check("ar_bit_cnt",    {28'd0, bit_cnt}, 32'h0);
        tick(3);
        rst_n = 1'b1;
        data_ready = 1'b1;
        tick(5);
        exp_q.push_back(8'hFF);
        send_byte(8'hFF);
        tick(20);

        check("end_queue_empty", exp_q.size(), 32'd0);
        check("end_accepted",    accepted, 32'd8);
        check("end_frame_errs",  fe_cnt, 32'd1);
        check("end_overrun",     {31'd0, overrun}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
